// File: rtl/tc_encoder_pkg.sv
// Shared definitions for the request encoder: default width, index-width
// helper and the "more than one request" detector.
package tc_encoder_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int WIDTH_MAX     = 64;

  // Index width for a WIDTH-bit request vector; never narrower than one bit.
  function automatic int clog2_safe(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // True when at least two bits are set: clearing the lowest set bit
  // leaves something behind only if another bit was set.
  function automatic logic popcount_ge2(input logic [WIDTH_MAX-1:0] v);
    return (v & (v - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Combinational picker: first set bit of req scanning upward from ptr and
// wrapping at WIDTH. With ptr tied to zero it is a lowest-index priority
// encoder. sel is meaningful only when any=1.
module tc_rr_pick
  import tc_encoder_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  localparam logic [IDX_W:0] SPAN = (IDX_W+1)'(WIDTH);

  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotating right by ptr puts request ptr at bit 0, so the lowest set bit
  // of w_rot is the first hit of the circular scan.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: WIDTH];
  assign any   = |req;

  // Lowest set bit of the rotated vector, as an offset from ptr.
  always_comb begin
    // NOTE: default first so every path assigns w_off; otherwise a latch is inferred.
    w_off = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  // Add ptr back, folding modulo WIDTH (works for non-power-of-2 WIDTH).
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign sel   = (w_sum >= SPAN) ? IDX_W'(w_sum - SPAN) : IDX_W'(w_sum);

endmodule

// File: rtl/tc_encoder_rr.sv
// Registered N-to-log2(N) request encoder with a one-entry output buffer and
// valid/ready handshakes on both sides.
// Build option: define TC_ENCODER_RR_EN for round-robin selection using a
// rotating priority pointer; without it the lowest set request wins and no
// pointer register exists.
module tc_encoder_rr
  import tc_encoder_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = clog2_safe(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi
);

  logic             w_accept;
  logic             w_any;
  logic             w_multi;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_ptr;

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_zero;
  logic             r_multi;

  // The buffer can take a new request when empty or being drained now.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_multi  = popcount_ge2(WIDTH_MAX'(req));

  tc_rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req (req),
    .ptr (w_ptr),
    .sel (w_sel),
    .any (w_any)
  );

`ifdef TC_ENCODER_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] r_ptr;

  // Priority pointer moves just past the winner; zero requests leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept && w_any) begin
      r_ptr <= (w_sel == LAST_IDX) ? '0 : w_sel + IDX_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Output buffer: load on accept, clear valid on a drain with no refill;
  // the payload fields keep their last values once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_zero  <= 1'b0;
      r_multi <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_idx   <= w_any ? w_sel : '0;
      r_zero  <= !w_any;
      r_multi <= w_multi;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_zero  = r_zero;
  assign out_multi = r_multi;

endmodule

// File: tb/tb_tc_encoder_rr.sv
// Bench for tc_encoder_rr: a WIDTH=4 instance driven from a vector table plus
// hand-written back-pressure and reset sequences, and a WIDTH=3 instance for
// the zero-request and pointer-wrap case. Expected values follow the build
// option TC_ENCODER_RR_EN (round-robin) or its absence (lowest index wins).
module tb_tc_encoder_rr;

`ifdef TC_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_zero;
  logic       out_multi;

  logic       w3_in_valid;
  logic       w3_in_ready;
  logic [2:0] w3_req;
  logic       w3_out_valid;
  logic       w3_out_ready;
  logic [1:0] w3_out_idx;
  logic       w3_out_zero;
  logic       w3_out_multi;

  int n_checks = 0;
  int n_errors = 0;

  tc_encoder_rr #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_multi (out_multi)
  );

  tc_encoder_rr #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w3_in_valid),
    .in_ready  (w3_in_ready),
    .req       (w3_req),
    .out_valid (w3_out_valid),
    .out_ready (w3_out_ready),
    .out_idx   (w3_out_idx),
    .out_zero  (w3_out_zero),
    .out_multi (w3_out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_valid;
    logic [3:0] req;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic       exp_zero;
    logic       exp_multi;
    logic [1:0] exp_ptr;
  } vec_t;

  localparam int N_VEC = 14;
  vec_t vecs [N_VEC];

  function automatic vec_t mk(input logic iv, input logic [3:0] r, input logic ordy,
                              input logic e_ir, input logic e_v, input logic [1:0] e_idx,
                              input logic e_z, input logic e_m, input logic [1:0] e_ptr);
    vec_t v;
    v.in_valid = iv;   v.req = r;         v.out_ready = ordy;
    v.exp_in_ready = e_ir; v.exp_valid = e_v; v.exp_idx = e_idx;
    v.exp_zero = e_z;  v.exp_multi = e_m; v.exp_ptr = e_ptr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] r, input logic ordy);
    in_valid  = iv;
    req       = r;
    out_ready = ordy;
  endtask

  task automatic drive3(input logic iv, input logic [2:0] r, input logic ordy);
    w3_in_valid  = iv;
    w3_req       = r;
    w3_out_ready = ordy;
  endtask

  task automatic check_ptr(input string name, input logic [1:0] act, input logic [1:0] exp);
`ifdef TC_ENCODER_RR_EN
    check(name, 32'(act), 32'(exp));
`endif
  endtask

  // Watchdog: the run is fixed-length, so reaching this means something hung.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream from reset (ptr=0). RR pointer after each row in the last field.
    vecs[0]  = mk(1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1);
    vecs[1]  = mk(1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd2);
    vecs[2]  = mk(1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd3);
    vecs[3]  = mk(1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
    vecs[4]  = mk(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 2'd0,             1'b0, 1'b1, 2'd1);
    vecs[5]  = mk(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, RR ? 2'd1 : 2'd0, 1'b0, 1'b1, 2'd2);
    vecs[6]  = mk(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, RR ? 2'd3 : 2'd0, 1'b0, 1'b1, 2'd0);
    vecs[7]  = mk(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 2'd0,             1'b0, 1'b1, 2'd1);
    vecs[8]  = mk(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0,             1'b1, 1'b0, 2'd1);
    vecs[9]  = mk(1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 2'd1,             1'b0, 1'b1, 2'd2);
    vecs[10] = mk(1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, RR ? 2'd2 : 2'd1, 1'b0, 1'b1, 2'd3);
    vecs[11] = mk(1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, RR ? 2'd3 : 2'd0, 1'b0, 1'b1, 2'd0);
    // Drain with no accept (req is don't-care), then idle with out_ready low.
    vecs[12] = mk(1'b0, 4'bxxxx, 1'b1, 1'b1, 1'b0, RR ? 2'd3 : 2'd0, 1'b0, 1'b1, 2'd0);
    vecs[13] = mk(1'b0, 4'bxxxx, 1'b0, 1'b1, 1'b0, RR ? 2'd3 : 2'd0, 1'b0, 1'b1, 2'd0);

    // ---- Reset values ----
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
    drive3(1'b0, 3'b000, 1'b1);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_idx",   32'(out_idx),   32'd0);
    check("reset out_zero",  32'(out_zero),  32'd0);
    check("reset out_multi", 32'(out_multi), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- Table-driven stream ----
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      drive(vecs[i].in_valid, vecs[i].req, vecs[i].out_ready);
      #1;
      check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d out_idx", i),   32'(out_idx),   32'(vecs[i].exp_idx));
      check($sformatf("row%0d out_zero", i),  32'(out_zero),  32'(vecs[i].exp_zero));
      check($sformatf("row%0d out_multi", i), 32'(out_multi), 32'(vecs[i].exp_multi));
`ifdef TC_ENCODER_RR_EN
      check_ptr($sformatf("row%0d ptr", i), dut.r_ptr, vecs[i].exp_ptr);
`endif
    end

    // ---- Back-pressure: hold idx 2 for three cycles, ignore new offers ----
    @(negedge clk);
    drive(1'b1, 4'b0100, 1'b1);
    @(posedge clk); #1;
    check("bp accept valid", 32'(out_valid), 32'd1);
    check("bp accept idx",   32'(out_idx),   32'd2);
    @(negedge clk);
    drive(1'b1, 4'b0001, 1'b0);
    #1;
    check("bp in_ready low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d idx", k),   32'(out_idx),   32'd2);
      check($sformatf("bp hold%0d multi", k), 32'(out_multi), 32'd0);
      @(negedge clk); #1;
      check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    drive(1'b1, 4'b1000, 1'b1);
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp next valid", 32'(out_valid), 32'd1);
    check("bp next idx",   32'(out_idx),   32'd3);
    @(negedge clk);
    drive(1'b1, 4'b0010, 1'b1);
    @(posedge clk); #1;
    check("bp full rate valid", 32'(out_valid), 32'd1);
    check("bp full rate idx",   32'(out_idx),   32'd1);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b1);
    @(posedge clk); #1;
    check("bp drained valid", 32'(out_valid), 32'd0);
    check("bp drained idx",   32'(out_idx),   32'd1);

    // ---- Asynchronous reset while an output is held ----
    @(negedge clk);
    drive(1'b1, 4'b1000, 1'b0);
    @(posedge clk); #1;
    check("rst pre valid", 32'(out_valid), 32'd1);
    check("rst pre idx",   32'(out_idx),   32'd3);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid valid",    32'(out_valid), 32'd0);
    check("rst mid idx",      32'(out_idx),   32'd0);
    check("rst mid in_ready", 32'(in_ready),  32'd1);
`ifdef TC_ENCODER_RR_EN
    check_ptr("rst mid ptr", dut.r_ptr, 2'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1011, 1'b1);
    @(posedge clk); #1;
    check("rst post idx",   32'(out_idx),   32'd0);
    check("rst post multi", 32'(out_multi), 32'd1);
    @(negedge clk);
    drive(1'b1, 4'b1011, 1'b1);
    @(posedge clk); #1;
    check("rst post2 idx", 32'(out_idx), RR ? 32'd1 : 32'd0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b1);

    // ---- WIDTH=3: zero request keeps ptr, then wrap from ptr=2 ----
    @(negedge clk);
    drive3(1'b1, 3'b010, 1'b1);
    @(posedge clk); #1;
    check("w3 set idx", 32'(w3_out_idx), 32'd1);
`ifdef TC_ENCODER_RR_EN
    check_ptr("w3 set ptr", dut3.r_ptr, 2'd2);
`endif
    @(negedge clk);
    drive3(1'b1, 3'b000, 1'b1);
    @(posedge clk); #1;
    check("w3 zero valid", 32'(w3_out_valid), 32'd1);
    check("w3 zero flag",  32'(w3_out_zero),  32'd1);
    check("w3 zero idx",   32'(w3_out_idx),   32'd0);
    check("w3 zero multi", 32'(w3_out_multi), 32'd0);
`ifdef TC_ENCODER_RR_EN
    check_ptr("w3 zero ptr", dut3.r_ptr, 2'd2);
`endif
    @(negedge clk);
    drive3(1'b1, 3'b101, 1'b1);
    @(posedge clk); #1;
    check("w3 wrap idx",   32'(w3_out_idx),   RR ? 32'd2 : 32'd0);
    check("w3 wrap zero",  32'(w3_out_zero),  32'd0);
    check("w3 wrap multi", 32'(w3_out_multi), 32'd1);
`ifdef TC_ENCODER_RR_EN
    check_ptr("w3 wrap ptr", dut3.r_ptr, 2'd0);
`endif
    @(negedge clk);
    drive3(1'b1, 3'b101, 1'b1);
    @(posedge clk); #1;
    check("w3 after wrap idx", 32'(w3_out_idx), 32'd0);
    @(negedge clk);
    drive3(1'b0, 3'b000, 1'b1);
    @(posedge clk); #1;
    check("w3 drained valid", 32'(w3_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
